// File: rtl/wb_rr_bus_pkg.sv
// Shared types, limits and the round-robin pick function for the wb_rr_bus interconnect.
package wb_rr_bus_pkg;

    localparam int unsigned MAX_M = 8;
    localparam int unsigned MAX_S = 16;
    localparam int unsigned GNT_W = 3;
    localparam int unsigned WD_W  = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // First requester after 'last', wrapping modulo n; returns 'last' when nobody requests.
    function automatic logic [GNT_W-1:0] rr_pick(input logic [MAX_M-1:0] req,
                                                 input logic [GNT_W-1:0] last,
                                                 input int unsigned      n);
        logic [GNT_W-1:0] pick;
        logic             found;
        int unsigned      idx;
        pick  = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= MAX_M; i++) begin
            idx = (32'(last) + i) % n;
            if (!found && (i <= n) && req[idx[GNT_W-1:0]]) begin
                pick  = idx[GNT_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/wb_rr_bus_arbiter.sv
// Round-robin bus arbiter: grants one cyc requester, holds it while its cyc stays high.
module wb_rr_arbiter
    import wb_rr_bus_pkg::*;
#(
    parameter int unsigned N_M = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N_M-1:0] req,
    output logic [N_M-1:0] gnt
);

    arb_state_e       state_q, state_d;
    logic [N_M-1:0]   gnt_d;
    logic [GNT_W-1:0] last_q, last_d;
    logic [GNT_W-1:0] pick;
    logic             held;

    assign held = |(req & gnt);
    assign pick = rr_pick(MAX_M'(req), last_q, N_M);

    // last_grant resets to the top master so master 0 wins the first arbitration
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            gnt     <= '0;
            last_q  <= GNT_W'(N_M - 1);
        end else begin
            state_q <= state_d;
            gnt     <= gnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (|req) state_d = ST_BUSY;
            ST_BUSY: if (!held) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A release always passes through IDLE, so no grant lands in the release cycle
    always_comb begin
        gnt_d  = gnt;
        last_d = last_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    last_d = pick;
                    for (int unsigned i = 0; i < N_M; i++) gnt_d[i] = (pick == GNT_W'(i));
                end
            end
            ST_BUSY: if (!held) gnt_d = '0;
            default: gnt_d = '0;
        endcase
    end

endmodule

// File: rtl/wb_rr_bus.sv
// Shared-bus Wishbone interconnect: round-robin master arbitration, mask/base slave decode,
// decode-miss error, optional stuck-slave watchdog (WB_RR_BUS_TIMEOUT_EN).
module wb_rr_bus
    import wb_rr_bus_pkg::*;
#(
    parameter int unsigned          N_M     = 4,
    parameter int unsigned          N_S     = 8,
    parameter int unsigned          ADR_W   = 32,
    parameter int unsigned          DAT_W   = 32,
    parameter logic [N_S*ADR_W-1:0] S_BASE  = '0,
    parameter logic [N_S*ADR_W-1:0] S_MASK  = '0,
    parameter int unsigned          TIMEOUT = 255,
    localparam int unsigned         SEL_W   = DAT_W / 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_M*ADR_W-1:0] m_adr_i,
    input  logic [N_M*DAT_W-1:0] m_dat_i,
    input  logic [N_M*SEL_W-1:0] m_sel_i,
    input  logic [N_M-1:0]       m_we_i,
    input  logic [N_M-1:0]       m_cyc_i,
    input  logic [N_M-1:0]       m_stb_i,
    output logic [DAT_W-1:0]     m_dat_o,
    output logic [N_M-1:0]       m_ack_o,
    output logic [N_M-1:0]       m_err_o,
    output logic [N_M-1:0]       m_rty_o,
    output logic [ADR_W-1:0]     s_adr_o,
    output logic [DAT_W-1:0]     s_dat_o,
    output logic [SEL_W-1:0]     s_sel_o,
    output logic                 s_we_o,
    output logic [N_S-1:0]       s_cyc_o,
    output logic [N_S-1:0]       s_stb_o,
    input  logic [N_S*DAT_W-1:0] s_dat_i,
    input  logic [N_S-1:0]       s_ack_i,
    input  logic [N_S-1:0]       s_err_i,
    input  logic [N_S-1:0]       s_rty_i
);

    logic [N_M-1:0]   gnt;
    logic [ADR_W-1:0] g_adr;
    logic [DAT_W-1:0] g_dat;
    logic [SEL_W-1:0] g_sel;
    logic             g_we, g_cyc, g_stb;
    logic [N_S-1:0]   hit_oh, sel_oh;
    logic             hit;
    logic [DAT_W-1:0] r_dat;
    logic             r_ack, r_err, r_rty;
    logic             miss_err_q;
    logic             wd_err;
    logic             resp_ack, resp_err, resp_rty;

    wb_rr_arbiter #(.N_M(N_M)) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (m_cyc_i),
        .gnt     (gnt)
    );

    // Granted master's request; all zero when nobody owns the bus
    always_comb begin
        g_adr = '0;
        g_dat = '0;
        g_sel = '0;
        g_we  = 1'b0;
        g_cyc = 1'b0;
        g_stb = 1'b0;
        for (int unsigned i = 0; i < N_M; i++) begin
            if (gnt[i]) begin
                g_adr = m_adr_i[i*ADR_W +: ADR_W];
                g_dat = m_dat_i[i*DAT_W +: DAT_W];
                g_sel = m_sel_i[i*SEL_W +: SEL_W];
                g_we  = m_we_i[i];
                g_cyc = m_cyc_i[i];
                g_stb = m_stb_i[i];
            end
        end
    end

    // Lowest-index matching slave wins
    always_comb begin
        hit_oh = '0;
        hit    = 1'b0;
        for (int unsigned j = 0; j < N_S; j++) begin
            if (!hit && ((g_adr & S_MASK[j*ADR_W +: ADR_W]) == S_BASE[j*ADR_W +: ADR_W])) begin
                hit_oh[j] = 1'b1;
                hit       = 1'b1;
            end
        end
    end

    // g_cyc gates everything so a dropped cyc aborts at once and late acks are discarded
    assign sel_oh  = g_cyc ? hit_oh : '0;
    assign s_cyc_o = sel_oh;
    assign s_stb_o = g_stb ? sel_oh : '0;
    assign s_adr_o = g_adr;
    assign s_dat_o = g_dat;
    assign s_sel_o = g_sel;
    assign s_we_o  = g_we;

    always_comb begin
        r_dat = '0;
        r_ack = 1'b0;
        r_err = 1'b0;
        r_rty = 1'b0;
        for (int unsigned j = 0; j < N_S; j++) begin
            if (sel_oh[j]) begin
                r_dat = s_dat_i[j*DAT_W +: DAT_W];
                r_ack = s_ack_i[j];
                r_err = s_err_i[j];
                r_rty = s_rty_i[j];
            end
        end
    end

    // One err pulse per miss strobe, one cycle after the strobe is seen
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) miss_err_q <= 1'b0;
        else          miss_err_q <= g_cyc & g_stb & !hit & !miss_err_q;
    end

`ifdef WB_RR_BUS_TIMEOUT_EN
    logic [WD_W-1:0] wd_q;
    logic            wd_err_q;
    logic            wd_run;

    assign wd_run = g_cyc & g_stb & hit & !(r_ack | r_err | r_rty) & !wd_err_q;
    assign wd_err = wd_err_q;

    // Error is registered, so it appears in the cycle where the count would reach TIMEOUT
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_q     <= '0;
            wd_err_q <= 1'b0;
        end else begin
            wd_err_q <= 1'b0;
            if (!wd_run) begin
                wd_q <= '0;
            end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                wd_q     <= '0;
                wd_err_q <= 1'b1;
            end else begin
                wd_q <= wd_q + WD_W'(1);
            end
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^WD_W'(TIMEOUT);
    assign wd_err         = 1'b0;
`endif

    assign resp_ack = g_cyc & r_ack;
    assign resp_err = g_cyc & (r_err | miss_err_q | wd_err);
    assign resp_rty = g_cyc & r_rty;

    assign m_dat_o = r_dat;
    assign m_ack_o = {N_M{resp_ack}} & gnt;
    assign m_err_o = {N_M{resp_err}} & gnt;
    assign m_rty_o = {N_M{resp_rty}} & gnt;

endmodule

// File: tb/tb_wb_rr_bus.sv
// Scoreboard bench for wb_rr_bus: 4 masters, 5 slaves; builds with or without WB_RR_BUS_TIMEOUT_EN.
module tb_wb_rr_bus;

    localparam int unsigned NM = 4;
    localparam int unsigned NS = 5;
    localparam logic [2:0]  K_ACK = 3'b001;
    localparam logic [2:0]  K_ERR = 3'b010;
    localparam logic [2:0]  K_RTY = 3'b100;

    // s0 0x1xxx_xxxx, s1 0x2xxx_xxxx, s2 0x0xxx_xxxx, s3 0x12xx_xxxx (shadowed by s0), s4 0x3xxx_xxxx
    localparam logic [NS*32-1:0] BASE = {32'h3000_0000, 32'h1200_0000, 32'h0000_0000,
                                         32'h2000_0000, 32'h1000_0000};
    localparam logic [NS*32-1:0] MASK = {32'hF000_0000, 32'hFF00_0000, 32'hF000_0000,
                                         32'hF000_0000, 32'hF000_0000};

    typedef struct packed {
        logic [3:0]  m;
        logic [2:0]  kind;
        logic [31:0] dat;
        logic [7:0]  gap;
    } exp_t;

    logic             clk;
    logic             reset_n;
    logic [NM*32-1:0] m_adr_i;
    logic [NM*32-1:0] m_dat_i;
    logic [NM*4-1:0]  m_sel_i;
    logic [NM-1:0]    m_we_i, m_cyc_i, m_stb_i;
    logic [31:0]      m_dat_o;
    logic [NM-1:0]    m_ack_o, m_err_o, m_rty_o;
    logic [31:0]      s_adr_o, s_dat_o;
    logic [3:0]       s_sel_o;
    logic             s_we_o;
    logic [NS-1:0]    s_cyc_o, s_stb_o;
    logic [NS*32-1:0] s_dat_i;
    logic [NS-1:0]    s_ack_i, s_err_i, s_rty_i;
    logic [NS-1:0]    ack_en, rty_en, late_ack;

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc_cnt = 0;
    int   last_cyc = 0;
    exp_t sb[$];

    wb_rr_bus #(
        .N_M(NM), .N_S(NS), .ADR_W(32), .DAT_W(32),
        .S_BASE(BASE), .S_MASK(MASK), .TIMEOUT(20)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [31:0] slv_dat(input int j);
        return (j == 2) ? 32'hDEAD_BEEF : 32'h5100_0000 + 32'(j);
    endfunction

    // Reference decode written from the address map above, first match wins
    function automatic int tb_decode(input logic [31:0] adr);
        if (adr[31:28] == 4'h1) return 0;
        if (adr[31:28] == 4'h2) return 1;
        if (adr[31:28] == 4'h0) return 2;
        if (adr[31:28] == 4'h3) return 4;
        return -1;
    endfunction

    // Zero-wait slave models
    always_comb begin
        for (int j = 0; j < NS; j++) begin
            s_dat_i[j*32 +: 32] = slv_dat(j);
            s_ack_i[j] = (s_stb_o[j] & ack_en[j] & !rty_en[j]) | late_ack[j];
            s_rty_i[j] = s_stb_o[j] & rty_en[j];
            s_err_i[j] = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input int m, input logic [2:0] kind, input logic [31:0] dat,
                            input int gap);
        exp_t e;
        e.m    = 4'(m);
        e.kind = kind;
        e.dat  = dat;
        e.gap  = 8'(gap);
        sb.push_back(e);
    endtask

    // Response monitor: every master response pops and checks one scoreboard entry
    always @(negedge clk) begin
        exp_t e;
        for (int m = 0; m < NM; m++) begin
            if (m_ack_o[m] | m_err_o[m] | m_rty_o[m]) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 64'(m), 64'hFF);
                end else begin
                    e = sb.pop_front();
                    check("resp_master", 64'(m), 64'(e.m));
                    check("resp_kind", {m_rty_o[m], m_err_o[m], m_ack_o[m]}, 64'(e.kind));
                    check("resp_data", m_dat_o, 64'(e.dat));
                    if (e.gap != 0) check("resp_gap", 64'(cyc_cnt - last_cyc), 64'(e.gap));
                    last_cyc = cyc_cnt;
                end
            end
        end
    end

    task automatic drive_req(input int m, input logic [31:0] adr, input logic we,
                             input logic [31:0] wdat, input logic [3:0] sel);
        m_adr_i[m*32 +: 32] = adr;
        m_dat_i[m*32 +: 32] = wdat;
        m_sel_i[m*4 +: 4]   = sel;
        m_we_i[m]  = we;
        m_cyc_i[m] = 1'b1;
        m_stb_i[m] = 1'b1;
    endtask

    task automatic drop_req(input int m);
        m_cyc_i[m] = 1'b0;
        m_stb_i[m] = 1'b0;
    endtask

    // One transfer from an idle bus, with grant latency and broadcast checks
    task automatic single_xfer(input int m, input logic [31:0] adr, input logic we,
                               input logic [31:0] wdat, input logic [3:0] sel);
        int            j;
        logic [NS-1:0] oh;
        j  = tb_decode(adr);
        oh = (j < 0) ? '0 : NS'(1) << j;
        @(posedge clk); #1;
        drive_req(m, adr, we, wdat, sel);
        @(negedge clk);
        check("grant_latency", s_stb_o, 0);
        if (j < 0)          push_exp(m, K_ERR, 32'h0, 0);
        else if (rty_en[j]) push_exp(m, K_RTY, slv_dat(j), 0);
        else                push_exp(m, K_ACK, slv_dat(j), 0);
        @(negedge clk);
        check("stb_select", s_stb_o, oh);
        check("cyc_select", s_cyc_o, oh);
        check("s_adr", s_adr_o, adr);
        check("s_dat", s_dat_o, wdat);
        check("s_sel", s_sel_o, sel);
        check("s_we", s_we_o, we);
        if (j < 0) begin
            check("miss_err_early", m_err_o, 0);
            @(negedge clk);
            check("miss_err_pulse", m_err_o, NM'(1) << m);
        end
        @(posedge clk); #1;
        drop_req(m);
        @(negedge clk);
        check("quiet", {m_ack_o, m_err_o, m_rty_o}, 0);
    endtask

    // Bus master: n_cyc cycles, each with n_stb back-to-back strobe phases
    task automatic master_run(input int m, input int n_cyc, input logic [31:0] adr,
                              input int n_stb);
        logic got;
        for (int c = 0; c < n_cyc; c++) begin
            @(posedge clk); #1;
            drive_req(m, adr, 1'b0, 32'h0, 4'hF);
            for (int s = 0; s < n_stb; s++) begin
                got = 1'b0;
                for (int t = 0; t < 200 && !got; t++) begin
                    @(negedge clk);
                    got = m_ack_o[m] | m_err_o[m] | m_rty_o[m];
                end
                check("master_wait", got, 1);
                @(posedge clk); #1;
                if (s == n_stb - 1) drop_req(m);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int   k;
        logic seen;
        reset_n  = 1'b0;
        m_adr_i  = '0;
        m_dat_i  = '0;
        m_sel_i  = '0;
        m_we_i   = '0;
        m_cyc_i  = '0;
        m_stb_i  = '0;
        ack_en   = '1;
        rty_en   = '0;
        late_ack = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_stb", s_stb_o, 0);
        check("rst_cyc", s_cyc_o, 0);
        check("rst_resp", {m_ack_o, m_err_o, m_rty_o}, 0);
        check("rst_dat", m_dat_o, 0);

        // Basic decode: read, write, overlapping windows, retry, misses
        single_xfer(0, 32'h0000_0010, 1'b0, 32'h0, 4'hF);
        single_xfer(3, 32'h2000_0004, 1'b1, 32'hCAFE_F00D, 4'h3);
        single_xfer(2, 32'h1200_0000, 1'b0, 32'h0, 4'hF);
        ack_en[4] = 1'b0;
        rty_en[4] = 1'b1;
        single_xfer(1, 32'h3000_0008, 1'b0, 32'h0, 4'hF);
        rty_en[4] = 1'b0;
        ack_en[4] = 1'b1;
        single_xfer(0, 32'h9000_0000, 1'b0, 32'h0, 4'hF);
        single_xfer(2, 32'h4000_0000, 1'b1, 32'h1234_5678, 4'h8);

        // Lock: m1 keeps cyc for 4 phases, m0 waits, then gets the bus after the idle cycle
        push_exp(1, K_ACK, slv_dat(1), 0);
        for (int i = 0; i < 3; i++) push_exp(1, K_ACK, slv_dat(1), 1);
        push_exp(0, K_ACK, slv_dat(2), 3);
        fork
            master_run(1, 1, 32'h2000_0010, 4);
            begin
                repeat (3) @(posedge clk);
                master_run(0, 1, 32'h0000_0010, 1);
            end
        join
        @(negedge clk);

        // Stuck slave
        ack_en[2] = 1'b0;
`ifdef WB_RR_BUS_TIMEOUT_EN
        push_exp(0, K_ERR, slv_dat(2), 0);
`endif
        @(posedge clk); #1;
        drive_req(0, 32'h0000_0040, 1'b0, 32'h0, 4'hF);
        @(negedge clk);
        k    = 1000;
        seen = 1'b0;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (m_err_o[0]) begin
                k    = t;
                seen = 1'b1;
                break;
            end
        end
`ifdef WB_RR_BUS_TIMEOUT_EN
        check("wd_cycle", 64'(k), 20);
`else
        check("wd_absent", seen, 0);
`endif
        @(posedge clk); #1;
        drop_req(0);
        @(negedge clk);

        // Abort: a slave ack after cyc falls must not reach the master
        @(posedge clk); #1;
        drive_req(0, 32'h0000_0040, 1'b0, 32'h0, 4'hF);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        drop_req(0);
        late_ack[2] = 1'b1;
        @(negedge clk);
        check("abort_stb", s_stb_o, 0);
        check("abort_ack", m_ack_o, 0);
        @(posedge clk); #1;
        late_ack[2] = 1'b0;

        // Reset mid-transfer drops everything immediately
        @(posedge clk); #1;
        drive_req(1, 32'h0000_0040, 1'b0, 32'h0, 4'hF);
        repeat (2) @(negedge clk);
        check("busy_stb", s_stb_o, 5'b00100);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_stb", s_stb_o, 0);
        check("async_rst_cyc", s_cyc_o, 0);
        check("async_rst_resp", {m_ack_o, m_err_o, m_rty_o}, 0);
        drop_req(1);
        ack_en = '1;
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Fairness from reset: order 0,1,3,0,1,3 with one idle cycle between owners
        for (int r = 0; r < 2; r++) begin
            push_exp(0, K_ACK, slv_dat(2), (r == 0) ? 0 : 3);
            push_exp(1, K_ACK, slv_dat(1), 3);
            push_exp(3, K_ACK, slv_dat(4), 3);
        end
        fork
            master_run(0, 2, 32'h0000_0020, 1);
            master_run(1, 2, 32'h2000_0000, 1);
            master_run(3, 2, 32'h3000_0000, 1);
        join
        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_rr_bus.md
# wb_rr_bus

Parametrised shared-bus Wishbone interconnect; the next-generation replacement for the fixed 8x8 bus in the LM32 SoC top level. It connects N_M masters (LM32 I/D, future DMA) to N_S slaves (BRAM, DDR, UART, timer) through one shared path. It uses fair round-robin arbitration, mask/base address decode from parameters, a decode-miss error response and an optional stuck-slave watchdog.

## Interface
- N_M, 4: number of masters, 1..8
- N_S, 8: number of slaves, 1..16
- ADR_W, 32: address width
- DAT_W, 32: data width; SEL_W = DAT_W/8
- S_BASE, {N_S{32'h0}}: packed per-slave base addresses, slave i at [i*ADR_W +: ADR_W]
- S_MASK, {N_S{32'h0}}: packed per-slave masks; slave i hit when (adr & mask_i) == base_i
- TIMEOUT, 255: watchdog cycle limit, 1..65535

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i  in  N_M x (ADR_W, DAT_W, SEL_W, 1, 1, 1)  packed master request buses
- m_dat_o  out  DAT_W  shared read data, broadcast to all masters
- m_ack_o, m_err_o, m_rty_o  out  N_M  per-master responses
- s_adr_o, s_dat_o, s_sel_o, s_we_o  out  ADR_W, DAT_W, SEL_W, 1  shared slave request, broadcast
- s_cyc_o, s_stb_o  out  N_S  per-slave cycle and strobe
- s_dat_i, s_ack_i, s_err_i, s_rty_i  in  N_S x (DAT_W, 1, 1, 1)  packed slave responses

## Operation
- The arbiter FSM has two states: IDLE and BUSY.
- IDLE: if any m_cyc_i is high, grant the first requester searching from last_grant+1, wrapping modulo N_M. Register gnt and enter BUSY on the next edge.
- BUSY: the granted master owns the bus while its m_cyc_i is high, including across multiple stb phases (bus lock). When its cyc falls, return to IDLE.
- Requests are never granted in the same cycle as a release.
- Decode is combinational on the granted address. The lowest-index matching slave wins. s_cyc_o/s_stb_o drive only that slave.
- Decode miss: no slave is strobed. The bus returns a registered m_err_o pulse one cycle after stb is seen, for exactly one cycle per stb.
- Responses: the selected slave's ack/err/rty route combinationally to the granted master only. Other masters see 0. m_dat_o is the selected slave's s_dat_i, and is 0 on a miss.
- A master that drops cyc mid-transfer aborts the transfer. Any slave ack arriving afterwards is discarded.

## Timing
- Reset values: state IDLE, gnt 0, last_grant N_M-1 (so master 0 wins first), all s_cyc_o/s_stb_o 0, all m_ack_o/m_err_o/m_rty_o 0, watchdog 0.
- Grant latency: 1 cycle from m_cyc_i rising in IDLE to s_stb_o.
- Data/ack path once granted: 0 added cycles in both directions.
- Release-to-next-grant: 1 idle cycle.
- Simultaneous requests: the round-robin order above decides. A master that has just held the bus is lowest priority next.
- Asserting reset_n low mid-transfer drops all strobes immediately (asynchronous). No response is generated.

## Configuration
- WB_RR_BUS_TIMEOUT_EN defined:
  - A 16-bit watchdog counts cycles while s_stb_o is high and no ack/err/rty has arrived.
  - At count == TIMEOUT, m_err_o pulses 1 cycle to the granted master and the counter clears.
  - The counter also clears on any response or when stb falls.
- Not defined: no counter logic. A stuck slave hangs the bus until reset.

## Structure
- Package wb_rr_bus_pkg holds:
  - the arbiter state enum (ST_IDLE, ST_BUSY)
  - the max-width constants (MAX_M = 8, MAX_S = 16)
  - a function rr_pick(req, last) returning the next grant index
- Sub-module wb_rr_arbiter (N_M) holds the FSM and grant/last_grant registers and outputs a one-hot gnt. Decode and muxing stay in wb_rr_bus.

## Test plan
- Single master: m0 reads 0x0000_0010 with slave 2 = base 0x0000_0000 / mask 0xF000_0000 -> s_stb_o[2] high 1 cycle after cyc; s_dat_i 0xDEADBEEF is returned on m_dat_o with m_ack_o[0].
- Fairness: m0, m1 and m3 request continuously, each releasing after one ack -> grant order 0, 1, 3, 0, 1, 3; m2 never acked; 1 idle cycle between grants.
- Lock: m1 holds cyc across 4 stb phases while m0 requests -> m0 stays ungranted until m1's cyc falls, then m0 is granted after 1 cycle.
- Decode miss: m0 accesses 0x9000_0000 with no matching slave -> no s_stb_o; m_err_o[0] high for exactly 1 cycle, one cycle after stb.
- Timeout (macro on, TIMEOUT = 20): slave never acks -> m_err_o pulses at cycle 20 of stb; with the macro off, no err after 1000 cycles.
- Reset mid-transfer: reset_n low during a BUSY burst -> all outputs 0 at once; after release, master 0 has priority.
